// File: rtl/hazard_pkg.sv
// Shared types and helpers for the load-use stall/flush controller.
package hazard_pkg;

    // Controller FSM: IDLE covers the first bubble combinationally, LSTALL the rest.
    typedef enum logic {IDLE, LSTALL} stall_state_t;

    // Register x0 is hard-wired to zero and never creates a dependency.
    localparam int unsigned REG_ZERO = 0;

    // Remaining-bubble counter width; LOAD_LAT is at most 8, so LOAD_LAT-2 fits in 3 bits.
    localparam int unsigned CNT_BITS = 3;

    // Winning hazard cause for the current cycle.
    typedef enum logic [1:0] {
        CauseNone,
        CauseLoad,
        CauseBranch,
        CauseMemBusy
    } hz_cause_t;

    // Priority: memory freeze beats redirect, redirect beats load-use stall.
    function automatic hz_cause_t hz_prio(input logic mem_busy, input logic pc_src,
                                          input logic stall_req);
        if (mem_busy) begin
            return CauseMemBusy;
        end else if (pc_src) begin
            return CauseBranch;
        end else if (stall_req) begin
            return CauseLoad;
        end
        return CauseNone;
    endfunction

endpackage

// File: rtl/load_use_stall_ctrl_sat_counter.sv
// Saturating up-counter: increments on inc, sticks at all-ones.
module sat_counter #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    // Count enabled cycles; hold once every bit is set instead of wrapping.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: rtl/load_use_stall_ctrl.sv
// Stall/flush controller for hazards the forwarding network cannot cover:
// load-use dependencies, taken redirects resolved in E and a global memory freeze.
module load_use_stall_ctrl
    import hazard_pkg::*;
#(
    parameter int unsigned LOAD_LAT = 1,
    parameter int unsigned REG_AW   = 5,
    parameter int unsigned CNT_W    = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_AW-1:0] RS1D,
    input  logic [REG_AW-1:0] RS2D,
    input  logic [REG_AW-1:0] RDE,
    input  logic              ResultSrcE0,
    input  logic              PCSrcE,
    input  logic              MemBusy,
    output logic              StallF,
    output logic              StallD,
    output logic              StallE,
    output logic              StallM,
    output logic              StallW,
    output logic              FlushD,
    output logic              FlushE,
    output logic              LoadStallActive,
    output logic [CNT_W-1:0]  StallCount
);

    stall_state_t          state_q, state_d;
    logic [CNT_BITS-1:0]   cnt_q, cnt_d;
    logic                  lw_haz;
    logic                  stall_req;
    hz_cause_t             cause;

    // Load in E feeding a source of the instruction in D; x0 is excluded.
    assign lw_haz = ResultSrcE0 && (RDE != REG_AW'(REG_ZERO)) &&
                    ((RDE == RS1D) || (RDE == RS2D));

    // Once in LSTALL the remaining bubbles are owed regardless of what sits in E.
    assign stall_req = (state_q == LSTALL) || lw_haz;
    assign cause     = hz_prio(MemBusy, PCSrcE, stall_req);

    assign LoadStallActive = (state_q == LSTALL);

    // State and remaining-bubble register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state and stall/flush outputs, decoded from the winning cause.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        StallF  = 1'b0;
        StallD  = 1'b0;
        StallE  = 1'b0;
        StallM  = 1'b0;
        StallW  = 1'b0;
        FlushD  = 1'b0;
        FlushE  = 1'b0;
        if (!reset) begin
            unique case (cause)
                CauseMemBusy: begin
                    // Freeze everything, including the FSM; nothing new is latched.
                    StallF = 1'b1;
                    StallD = 1'b1;
                    StallE = 1'b1;
                    StallM = 1'b1;
                    StallW = 1'b1;
                end
                CauseBranch: begin
                    // Wrong-path instructions in D and E die; any owed bubbles are moot.
                    FlushD  = 1'b1;
                    FlushE  = 1'b1;
                    state_d = IDLE;
                    cnt_d   = '0;
                end
                CauseLoad: begin
                    StallF = 1'b1;
                    StallD = 1'b1;
                    FlushE = 1'b1;
                    if (state_q == IDLE) begin
                        if (LOAD_LAT > 1) begin
                            state_d = LSTALL;
                            cnt_d   = CNT_BITS'(LOAD_LAT - 2);
                        end
                    end else if (cnt_q == '0) begin
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q - {{(CNT_BITS-1){1'b0}}, 1'b1};
                    end
                end
                CauseNone: begin
                end
                default: begin
                end
            endcase
        end
    end

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (StallF),
        .count (StallCount)
    );

endmodule

// File: tb/tb_load_use_stall_ctrl.sv
// Directed bench: two controllers (LOAD_LAT=3 with 32-bit counter, LOAD_LAT=1 with a
// 2-bit counter so saturation is reachable) share stimulus; per-cycle expectations go
// through a scoreboard queue and are popped when the outputs settle.
module tb_load_use_stall_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] rs1, rs2, rde;
    logic       ld, pc, mb;

    logic        sf3, sd3, se3, sm3, sw3, fd3, fe3, lsa3;
    logic [31:0] cnt3;
    logic        sf1, sd1, se1, sm1, sw1, fd1, fe1, lsa1;
    logic [1:0]  cnt1;

    int unsigned passed = 0;
    int unsigned total  = 0;

    typedef struct packed {
        logic [7:0]  o3;
        logic [31:0] c3;
        logic [1:0]  o1;
        logic [1:0]  c1;
    } exp_t;

    exp_t sb[$];

    // Output vectors: {StallF,StallD,StallE,StallM,StallW,FlushD,FlushE,LoadStallActive}
    localparam logic [7:0] O_NONE = 8'b0000_0000;
    localparam logic [7:0] O_LD   = 8'b1100_0010;
    localparam logic [7:0] O_LDA  = 8'b1100_0011;
    localparam logic [7:0] O_BR   = 8'b0000_0110;
    localparam logic [7:0] O_BRA  = 8'b0000_0111;
    localparam logic [7:0] O_MBA  = 8'b1111_1001;
    localparam logic [7:0] O_MB   = 8'b1111_1000;
    // Second instance, {StallF, FlushE}
    localparam logic [1:0] P_NONE = 2'b00;
    localparam logic [1:0] P_LD   = 2'b11;
    localparam logic [1:0] P_BR   = 2'b01;
    localparam logic [1:0] P_MB   = 2'b10;

    always #5 clk = ~clk;

    load_use_stall_ctrl #(
        .LOAD_LAT (3),
        .REG_AW   (5),
        .CNT_W    (32)
    ) u_dut3 (
        .clk             (clk),
        .reset           (reset),
        .RS1D            (rs1),
        .RS2D            (rs2),
        .RDE             (rde),
        .ResultSrcE0     (ld),
        .PCSrcE          (pc),
        .MemBusy         (mb),
        .StallF          (sf3),
        .StallD          (sd3),
        .StallE          (se3),
        .StallM          (sm3),
        .StallW          (sw3),
        .FlushD          (fd3),
        .FlushE          (fe3),
        .LoadStallActive (lsa3),
        .StallCount      (cnt3)
    );

    load_use_stall_ctrl #(
        .LOAD_LAT (1),
        .REG_AW   (5),
        .CNT_W    (2)
    ) u_dut1 (
        .clk             (clk),
        .reset           (reset),
        .RS1D            (rs1),
        .RS2D            (rs2),
        .RDE             (rde),
        .ResultSrcE0     (ld),
        .PCSrcE          (pc),
        .MemBusy         (mb),
        .StallF          (sf1),
        .StallD          (sd1),
        .StallE          (se1),
        .StallM          (sm1),
        .StallW          (sw1),
        .FlushD          (fd1),
        .FlushE          (fe1),
        .LoadStallActive (lsa1),
        .StallCount      (cnt1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Drive one cycle of inputs (just after negedge), queue the expectation, compare
    // once the combinational outputs settle, then move to the next negedge.
    task automatic step(input string tag, input logic rst,
                        input logic [4:0] s1, input logic [4:0] s2, input logic [4:0] d,
                        input logic l, input logic p, input logic m,
                        input logic [7:0] o3, input logic [31:0] c3,
                        input logic [1:0] o1, input logic [1:0] c1);
        exp_t e;
        reset = rst;
        rs1   = s1;
        rs2   = s2;
        rde   = d;
        ld    = l;
        pc    = p;
        mb    = m;
        sb.push_back('{o3: o3, c3: c3, o1: o1, c1: c1});
        #2;
        e = sb.pop_front();
        check({tag, ".out3"}, 32'({sf3, sd3, se3, sm3, sw3, fd3, fe3, lsa3}), 32'(e.o3));
        check({tag, ".cnt3"}, cnt3, e.c3);
        check({tag, ".out1"}, 32'({sf1, fe1}), 32'(e.o1));
        check({tag, ".cnt1"}, 32'(cnt1), 32'(e.c1));
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1;
        rs1 = '0; rs2 = '0; rde = '0; ld = 1'b0; pc = 1'b0; mb = 1'b0;
        @(negedge clk);

        // Reset state; hazard present on inputs but outputs forced low
        step("rst_hz",   1, 5, 0, 5, 1, 0, 0, O_NONE, 0, P_NONE, 0);
        step("idle",     0, 0, 0, 0, 0, 0, 0, O_NONE, 0, P_NONE, 0);
        // Load x5 in E, D reads x5; E then holds a bubble while D stays stalled
        step("lu_b1",    0, 5, 0, 5, 1, 0, 0, O_LD,   0, P_LD,   0);
        step("lu_b2",    0, 5, 0, 0, 0, 0, 0, O_LDA,  1, P_NONE, 1);
        step("lu_b3",    0, 5, 0, 0, 0, 0, 0, O_LDA,  2, P_NONE, 1);
        step("lu_done",  0, 5, 0, 0, 0, 0, 0, O_NONE, 3, P_NONE, 1);
        // x0 never hazards; non-load writer never stalls
        step("x0_load",  0, 0, 0, 0, 1, 0, 0, O_NONE, 3, P_NONE, 1);
        step("nonload",  0, 0, 5, 5, 0, 0, 0, O_NONE, 3, P_NONE, 1);
        // Redirect overrides a simultaneous load-use hazard
        step("br_hz",    0, 5, 0, 5, 1, 1, 0, O_BR,   3, P_BR,   1);
        step("br_after", 0, 0, 0, 0, 0, 0, 0, O_NONE, 3, P_NONE, 1);
        // MemBusy for 4 cycles after bubble 1: freeze, then bubbles 2-3 resume
        step("mb_b1",    0, 5, 0, 5, 1, 0, 0, O_LD,   3, P_LD,   1);
        step("mb_1",     0, 5, 0, 0, 0, 0, 1, O_MBA,  4, P_MB,   2);
        step("mb_2",     0, 5, 0, 0, 0, 0, 1, O_MBA,  5, P_MB,   3);
        step("mb_3",     0, 5, 0, 0, 0, 0, 1, O_MBA,  6, P_MB,   3);
        step("mb_4",     0, 5, 0, 0, 0, 0, 1, O_MBA,  7, P_MB,   3);
        step("mb_b2",    0, 5, 0, 0, 0, 0, 0, O_LDA,  8, P_NONE, 3);
        step("mb_b3",    0, 5, 0, 0, 0, 0, 0, O_LDA,  9, P_NONE, 3);
        step("mb_done",  0, 0, 0, 0, 0, 0, 0, O_NONE, 10, P_NONE, 3);
        // Redirect held under MemBusy takes effect once the freeze lifts
        step("mb_br",    0, 0, 0, 0, 0, 1, 1, O_MB,   10, P_MB,  3);
        step("br_late",  0, 0, 0, 0, 0, 1, 0, O_BR,   11, P_BR,  3);
        // Redirect while in LSTALL abandons the remaining bubbles
        step("ls_b1",    0, 5, 0, 5, 1, 0, 0, O_LD,   11, P_LD,  3);
        step("ls_br",    0, 5, 0, 0, 0, 1, 0, O_BRA,  12, P_BR,  3);
        step("ls_idle",  0, 5, 0, 0, 0, 0, 0, O_NONE, 12, P_NONE, 3);
        // Reset in LSTALL: outputs forced low, state and counts cleared next edge
        step("rs_b1",    0, 5, 0, 5, 1, 0, 0, O_LD,   12, P_LD,  3);
        step("rs_mid",   1, 5, 0, 0, 0, 0, 0, 8'b0000_0001, 13, P_NONE, 3);
        step("rs_after", 0, 0, 0, 0, 0, 0, 0, O_NONE, 0, P_NONE, 0);
        // Held hazard via RS2D: 2-bit counter passes all-ones-1 and saturates at 3
        step("sat_1",    0, 0, 5, 5, 1, 0, 0, O_LD,   0, P_LD,   0);
        step("sat_2",    0, 0, 5, 5, 1, 0, 0, O_LDA,  1, P_LD,   1);
        step("sat_3",    0, 0, 5, 5, 1, 0, 0, O_LDA,  2, P_LD,   2);
        step("sat_4",    0, 0, 5, 5, 1, 0, 0, O_LD,   3, P_LD,   3);
        step("sat_5",    0, 0, 0, 0, 0, 0, 0, O_LDA,  4, P_NONE, 3);
        step("sat_6",    0, 0, 0, 0, 0, 0, 0, O_LDA,  5, P_NONE, 3);
        step("sat_7",    0, 0, 0, 0, 0, 0, 0, O_NONE, 6, P_NONE, 3);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
